// File: rtl/stepper_pulse_gen.sv
// Step/direction pulse generator: runs one motion job at a time on one of CH channels,
// emitting pulse_num step pulses of 2*half_period cycles after a direction setup delay.
//
// state | meaning
// IDLE  | ready, waiting for an accepted start
// SETUP | en_o/dir_o driven, holding off SETUP_CYC cycles before the first step
// HIGH  | step output high for hp cycles
// LOW   | step output low for hp cycles
// DONE  | one-cycle done pulse, enable still asserted
module stepper_pulse_gen #(
  parameter int CH        = 6,
  parameter int CNT_W     = 16,
  parameter int DIV_W     = 16,
  parameter int SETUP_CYC = 4
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                start,
  input  logic [(CH > 1 ? $clog2(CH) : 1)-1:0] sel,
  input  logic [CNT_W-1:0]                    pulse_num,
  input  logic [DIV_W-1:0]                    half_period,
  input  logic                                dir,
  input  logic                                abort,
  output logic                                ready,
  output logic                                busy,
  output logic                                done,
  output logic                                aborted,
  output logic                                err,
  output logic [CH-1:0]                       pu,
  output logic [CH-1:0]                       en_o,
  output logic [CH-1:0]                       dir_o,
  output logic [CNT_W-1:0]                    pulses_sent
);

  localparam int SEL_W = (CH > 1) ? $clog2(CH) : 1;
  localparam int SU_W  = $clog2(SETUP_CYC + 1);
  localparam int TMR_W = (DIV_W > SU_W) ? DIV_W : SU_W;
  localparam logic [SEL_W:0] CH_L = (SEL_W+1)'(CH);

  typedef enum logic [2:0] {S_IDLE, S_SETUP, S_HIGH, S_LOW, S_DONE} state_t;

  state_t           state, state_d;
  logic [SEL_W-1:0] sel_r, sel_r_d;
  logic [CNT_W-1:0] num_r, num_r_d;
  logic [DIV_W-1:0] hp_r, hp_r_d;
  logic [TMR_W-1:0] tmr, tmr_d;
  logic             abort_pend, abort_pend_d;
  logic [CNT_W-1:0] pulses_sent_d;
  logic             ready_d, busy_d, done_d, aborted_d, err_d;
  logic [CH-1:0]    pu_d, en_d, dir_o_d;
  logic [CH-1:0]    sel_mask, ch_mask;
  logic [DIV_W-1:0] hp_in;
  logic [TMR_W-1:0] hp_tmr;
  logic             sel_bad, tmr_zero;

  assign sel_bad  = ({1'b0, sel} >= CH_L);
  assign sel_mask = CH'(1) << sel;
  assign hp_in    = (half_period == '0) ? DIV_W'(1) : half_period;
  assign hp_tmr   = TMR_W'(hp_r) - TMR_W'(1);
  assign tmr_zero = (tmr == '0);

  always_comb begin
    state_d       = state;
    sel_r_d       = sel_r;
    num_r_d       = num_r;
    hp_r_d        = hp_r;
    tmr_d         = tmr;
    abort_pend_d  = abort_pend;
    pulses_sent_d = pulses_sent;
    aborted_d     = aborted;
    err_d         = 1'b0;
    en_d          = en_o;
    dir_o_d       = dir_o;
    case (state)
      S_IDLE: begin
        if (start) begin
          if (sel_bad) begin
            err_d = 1'b1;
          end else begin
            aborted_d     = 1'b0;
            pulses_sent_d = '0;
            abort_pend_d  = 1'b0;
            if (pulse_num == '0) begin
              state_d = S_DONE;
            end else begin
              sel_r_d = sel;
              num_r_d = pulse_num;
              hp_r_d  = hp_in;
              tmr_d   = TMR_W'(SETUP_CYC - 1);
              en_d    = sel_mask;
              dir_o_d = dir ? (dir_o | sel_mask) : (dir_o & ~sel_mask);
              state_d = S_SETUP;
            end
          end
        end
      end
      S_SETUP: begin
        if (abort) begin
          aborted_d = 1'b1;
          state_d   = S_DONE;
        end else if (tmr_zero) begin
          tmr_d   = hp_tmr;
          state_d = S_HIGH;
        end else begin
          tmr_d = tmr - TMR_W'(1);
        end
      end
      S_HIGH: begin
        // an abort here only takes effect once the high phase has run its full length
        if (abort) abort_pend_d = 1'b1;
        if (tmr_zero) begin
          pulses_sent_d = pulses_sent + CNT_W'(1);
          if (abort || abort_pend) begin
            aborted_d = 1'b1;
            state_d   = S_DONE;
          end else begin
            tmr_d   = hp_tmr;
            state_d = S_LOW;
          end
        end else begin
          tmr_d = tmr - TMR_W'(1);
        end
      end
      S_LOW: begin
        if (tmr_zero && (pulses_sent == num_r)) begin
          state_d = S_DONE;
        end else if (abort) begin
          aborted_d = 1'b1;
          state_d   = S_DONE;
        end else if (tmr_zero) begin
          tmr_d   = hp_tmr;
          state_d = S_HIGH;
        end else begin
          tmr_d = tmr - TMR_W'(1);
        end
      end
      S_DONE: begin
        abort_pend_d = 1'b0;
        en_d         = '0;
        state_d      = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    ch_mask = CH'(1) << sel_r_d;
    pu_d    = (state_d == S_HIGH) ? ch_mask : '0;
    ready_d = (state_d == S_IDLE);
    busy_d  = ~ready_d;
    done_d  = (state_d == S_DONE);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= S_IDLE;
      sel_r       <= '0;
      num_r       <= '0;
      hp_r        <= '0;
      tmr         <= '0;
      abort_pend  <= 1'b0;
      ready       <= 1'b1;
      busy        <= 1'b0;
      done        <= 1'b0;
      aborted     <= 1'b0;
      err         <= 1'b0;
      pu          <= '0;
      en_o        <= '0;
      dir_o       <= '0;
      pulses_sent <= '0;
    end else begin
      state       <= state_d;
      sel_r       <= sel_r_d;
      num_r       <= num_r_d;
      hp_r        <= hp_r_d;
      tmr         <= tmr_d;
      abort_pend  <= abort_pend_d;
      ready       <= ready_d;
      busy        <= busy_d;
      done        <= done_d;
      aborted     <= aborted_d;
      err         <= err_d;
      pu          <= pu_d;
      en_o        <= en_d;
      dir_o       <= dir_o_d;
      pulses_sent <= pulses_sent_d;
    end
  end

endmodule
